// File: rtl/sound_pkg.sv
// Shared sound definitions used by the sequencer and the PWM sound controller.
package sound_pkg;

  // Sound codes; the code is also the bit index in request/ack vectors.
  localparam logic [1:0] SND_PING = 2'd0;
  localparam logic [1:0] SND_PONG = 2'd1;
  localparam logic [1:0] SND_GO   = 2'd2;
  localparam logic [1:0] SND_STOP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot mask for a sound code.
  function automatic logic [3:0] code_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/sound_arbiter.sv
// Fixed-priority picker: the highest set request bit wins (stop > go > pong > ping).
module sound_arbiter
  import sound_pkg::*;
(
  input  logic [3:0] reqs,
  output logic [1:0] winner,
  output logic       valid
);

  // Priority encode the request set.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    winner = SND_PING;
    valid  = 1'b1;
    if (reqs[3])      winner = SND_STOP;
    else if (reqs[2]) winner = SND_GO;
    else if (reqs[1]) winner = SND_PONG;
    else if (reqs[0]) winner = SND_PING;
    else              valid  = 1'b0;
  end

endmodule

// File: rtl/sound_sequencer.sv
// Latches sound requests, grants one at a time by priority, and times each
// sound's play and trailing silent gap for the single sound_controller path.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned DUR_PING = 1_200_000,
  parameter int unsigned DUR_PONG = 1_200_000,
  parameter int unsigned DUR_GO   = 3_600_000,
  parameter int unsigned DUR_STOP = 6_000_000,
  parameter int unsigned GAP      = 240_000,
  parameter int unsigned CNT_W    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mute_in,
  output logic [2:0] code_sound,
  output logic       mute,
  output logic [3:0] ack,
  output logic       busy
);

  localparam logic [CNT_W-1:0] STOP_M1 = CNT_W'(DUR_STOP - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pending;

  logic [3:0]       grant_set;
  logic [1:0]       winner;
  logic             grant_valid;
  logic [3:0]       win_mask;
  logic [CNT_W-1:0] dur_m1;
  logic             preempt;

  assign grant_set = pending | req;
  assign win_mask  = code_onehot(winner);
  // A stop request cuts into any play or gap that is not already stop.
  assign preempt   = req[3] && (code_sound[1:0] != SND_STOP);

  sound_arbiter u_arbiter (
    .reqs   (grant_set),
    .winner (winner),
    .valid  (grant_valid)
  );

  // Duration reload for the current winner.
  always_comb begin
    dur_m1 = CNT_W'(DUR_PING - 1);
    unique case (winner)
      SND_PING: dur_m1 = CNT_W'(DUR_PING - 1);
      SND_PONG: dur_m1 = CNT_W'(DUR_PONG - 1);
      SND_GO:   dur_m1 = CNT_W'(DUR_GO - 1);
      SND_STOP: dur_m1 = CNT_W'(DUR_STOP - 1);
      default:  dur_m1 = CNT_W'(DUR_PING - 1);
    endcase
  end

  // Sequencer FSM with registered outputs; mute/busy are set for the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= '0;
      code_sound <= 3'b000;
      mute       <= 1'b1;
      ack        <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      ack     <= 4'b0000;
      pending <= pending | req;
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_PLAY;
            cnt        <= dur_m1;
            code_sound <= {1'b0, winner};
            ack        <= win_mask;
            pending    <= grant_set & ~win_mask;
            mute       <= mute_in;
            busy       <= 1'b1;
          end else begin
            mute <= 1'b1;
            busy <= 1'b0;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (preempt) begin
            state      <= ST_PLAY;
            cnt        <= STOP_M1;
            code_sound <= {1'b0, SND_STOP};
            ack        <= 4'b1000;
            pending    <= grant_set & 4'b0111;
            mute       <= mute_in;
            busy       <= 1'b1;
          end else if (cnt == '0) begin
            if (state == ST_PLAY && GAP > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_M1;
              mute  <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              mute  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            mute <= mute_in | (state != ST_PLAY);
            busy <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          mute  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with short durations; each cycle's
// observed {code_sound, mute, busy, ack} is compared to a hand-derived trace.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       mute_in = 1'b0;
  logic [2:0] code_sound;
  logic       mute;
  logic [3:0] ack;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  sound_sequencer #(
    .DUR_PING (4),
    .DUR_PONG (5),
    .DUR_GO   (6),
    .DUR_STOP (3),
    .GAP      (2),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mute_in    (mute_in),
    .code_sound (code_sound),
    .mute       (mute),
    .ack        (ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Packs an expected output vector as {code_sound, mute, busy, ack}.
  function automatic logic [8:0] pk(input int code, input bit m, input bit b, input logic [3:0] a);
    return {3'(code), m, b, a};
  endfunction

  function automatic logic [8:0] obs();
    return {code_sound, mute, busy, ack};
  endfunction

  task automatic test_reset();
    logic [8:0] got;
    rst = 1'b1;
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got = obs();
      checks++;
      if (got !== pk(0, 1, 0, 4'b0000)) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h expected=%h", i, got, pk(0, 1, 0, 4'b0000));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_ping();
    logic [8:0] got, exp;
    for (int i = 0; i < 7; i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      req = 4'b0000;
      if (i == 0)     exp = pk(0, 0, 1, 4'b0001);
      else if (i < 4) exp = pk(0, 0, 1, 4'b0000);
      else if (i < 6) exp = pk(0, 1, 1, 4'b0000);
      else            exp = pk(0, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_ping cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_pong_ping();
    logic [8:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      req = (i == 0) ? 4'b0011 : 4'b0000;
      @(posedge clk);
      #1;
      req = 4'b0000;
      if (i == 0)       exp = pk(1, 0, 1, 4'b0010);
      else if (i < 5)   exp = pk(1, 0, 1, 4'b0000);
      else if (i < 7)   exp = pk(1, 1, 1, 4'b0000);
      else if (i == 7)  exp = pk(1, 1, 0, 4'b0000);
      else if (i == 8)  exp = pk(0, 0, 1, 4'b0001);
      else if (i < 12)  exp = pk(0, 0, 1, 4'b0000);
      else if (i < 14)  exp = pk(0, 1, 1, 4'b0000);
      else              exp = pk(0, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pong_ping cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_preempt();
    logic [8:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      req = (i == 0) ? 4'b0100 : (i == 3) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      req = 4'b0000;
      if (i == 0)      exp = pk(2, 0, 1, 4'b0100);
      else if (i < 3)  exp = pk(2, 0, 1, 4'b0000);
      else if (i == 3) exp = pk(3, 0, 1, 4'b1000);
      else if (i < 6)  exp = pk(3, 0, 1, 4'b0000);
      else if (i < 8)  exp = pk(3, 1, 1, 4'b0000);
      else             exp = pk(3, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL preempt cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_mute_in();
    logic [8:0] got, exp;
    mute_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      req = 4'b0000;
      if (i == 0)     exp = pk(0, 1, 1, 4'b0001);
      else if (i < 6) exp = pk(0, 1, 1, 4'b0000);
      else            exp = pk(0, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mute_in cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
    mute_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [8:0] got, exp;
    for (int i = 0; i < 17; i++) begin
      req = (i <= 2 || i == 7) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      req = 4'b0000;
      if (i == 0)       exp = pk(0, 0, 1, 4'b0001);
      else if (i < 4)   exp = pk(0, 0, 1, 4'b0000);
      else if (i < 6)   exp = pk(0, 1, 1, 4'b0000);
      else if (i == 6)  exp = pk(0, 1, 0, 4'b0000);
      else if (i == 7)  exp = pk(0, 0, 1, 4'b0001);
      else if (i < 11)  exp = pk(0, 0, 1, 4'b0000);
      else if (i < 13)  exp = pk(0, 1, 1, 4'b0000);
      else              exp = pk(0, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [8:0] got, exp;
    for (int i = 0; i < 11; i++) begin
      req = (i == 0) ? 4'b0100 : (i == 1) ? 4'b0010 : 4'b0000;
      rst = (i == 2);
      @(posedge clk);
      #1;
      req = 4'b0000;
      rst = 1'b0;
      if (i == 0)      exp = pk(2, 0, 1, 4'b0100);
      else if (i == 1) exp = pk(2, 0, 1, 4'b0000);
      else             exp = pk(0, 1, 0, 4'b0000);
      got = obs();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rst_mid cyc=%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ping();
    test_pong_ping();
    test_preempt();
    test_mute_in();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
